uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_arb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the multi-requester UART transmit arbiter.
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int NUM_REQ_DEF     = 4;
    localparam int GAP_TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        NEXT      = 3'd4
    } arb_state_t;

    // Index width for n items; never zero so single-item configurations still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches upward from the entry after last_grant and returns the
// first active request as a one-hot vector plus its index.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any
);

    int   cand_s;
    logic found_s;

    // Priority search starting one past the previous owner, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = (int'(last_grant) + i) % NUM_REQ;
            if (!found_s && req[IW'(cand_s)]) begin
                found_s              = 1'b1;
                grant[IW'(cand_s)]   = 1'b1;
                grant_idx            = IW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one byte-wide UART transmitter between NUM_REQ packet sources; a grant is held
// for a whole packet and rotates round-robin between packets.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF,
    localparam int IW = idx_width(NUM_REQ),
    localparam int GW = idx_width(GAP_TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      uart_start,
    output logic [BYTE_W-1:0]         uart_data,
    input  logic                      uart_busy,
    output logic [IW-1:0]             grant_id,
    output logic                      grant_valid,
    output logic                      pkt_done,
    output logic                      err_timeout
);

    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

    arb_state_t          state_r, state_next_s;
    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IW-1:0]       arb_idx_s;
    logic                arb_any_s;
    logic [IW-1:0]       sel_idx_s;
    logic [BYTE_W-1:0]   sel_byte_s;
    logic                sel_last_s;
    logic                accept_s, gap_hit_s, done_evt_s, timeout_evt_s;

    logic [IW-1:0]       last_grant_r, grant_id_r;
    logic [GW-1:0]       gap_r;
    logic [BYTE_W-1:0]   uart_data_r;
    logic                last_r, grant_valid_r, uart_start_r, pkt_done_r, err_timeout_r;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s),
        .any        (arb_any_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:      if (accept_s) state_next_s = START; else state_next_s = IDLE;
            START:     state_next_s = WAIT_ACK;
            WAIT_ACK:  if (uart_busy) state_next_s = WAIT_DONE; else state_next_s = WAIT_ACK;
            WAIT_DONE: if (!uart_busy) state_next_s = last_r ? IDLE : NEXT;
                       else state_next_s = WAIT_DONE;
            NEXT: begin
                if (accept_s)       state_next_s = START;
                else if (gap_hit_s) state_next_s = IDLE;
                else                state_next_s = NEXT;
            end
            default:   state_next_s = IDLE;
        endcase
    end

    // Output logic: ready goes to the arbitration winner in IDLE, to the owner alone in NEXT.
    always_comb begin
        req_ready = '0;
        sel_idx_s = grant_id_r;
        case (state_r)
            IDLE: begin
                if (!uart_busy && arb_any_s) begin
                    req_ready = arb_grant_s;
                    sel_idx_s = arb_idx_s;
                end else begin
                    req_ready = '0;
                    sel_idx_s = grant_id_r;
                end
            end
            NEXT: begin
                req_ready[grant_id_r] = 1'b1;
                sel_idx_s             = grant_id_r;
            end
            default: req_ready = '0;
        endcase
    end

    // Byte and last-flag mux for the selected requester.
    always_comb begin
        sel_byte_s = '0;
        sel_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == sel_idx_s) begin
                sel_byte_s = req_data[i*BYTE_W +: BYTE_W];
                sel_last_s = req_last[i];
            end else begin
                sel_byte_s = sel_byte_s;
            end
        end
    end

    assign accept_s      = |(req_valid & req_ready);
    assign gap_hit_s     = (gap_r == GAP_LAST);
    assign done_evt_s    = (state_r == WAIT_DONE) && !uart_busy && last_r;
    assign timeout_evt_s = (state_r == NEXT) && !accept_s && gap_hit_s;

    // Accepted byte capture; uart_data only moves on accept, so it is stable while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uart_data_r <= '0;
            last_r      <= 1'b0;
            grant_id_r  <= '0;
        end else if (accept_s) begin
            uart_data_r <= sel_byte_s;
            last_r      <= sel_last_s;
            grant_id_r  <= sel_idx_s;
        end
    end

    // Packet ownership; last_grant advances only when a packet ends, so rotation is per packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_valid_r <= 1'b0;
            last_grant_r  <= LAST_INIT;
        end else if (accept_s) begin
            grant_valid_r <= 1'b1;
        end else if (done_evt_s || timeout_evt_s) begin
            grant_valid_r <= 1'b0;
            last_grant_r  <= grant_id_r;
        end
    end

    // Inter-byte gap counter, live only while waiting in NEXT.
    always_ff @(posedge clk) begin
        if (!rst_n)                                           gap_r <= '0;
        else if (state_r == NEXT && state_next_s == NEXT)     gap_r <= gap_r + GW'(1);
        else                                                  gap_r <= '0;
    end

    // Registered one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uart_start_r  <= 1'b0;
            pkt_done_r    <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            uart_start_r  <= (state_next_s == START);
            pkt_done_r    <= done_evt_s;
            err_timeout_r <= timeout_evt_s;
        end
    end

    assign uart_start  = uart_start_r;
    assign uart_data   = uart_data_r;
    assign grant_id    = grant_id_r;
    assign grant_valid = grant_valid_r;
    assign pkt_done    = pkt_done_r;
    assign err_timeout = err_timeout_r;

endmodule
